// File: rtl/fft_butterfly_sequencer_if.sv
// -----------------------------------------------------------------------------
// fft_butterfly_sequencer_if
//
// Purpose: bundles the control and butterfly-issue signals of the radix-2 DIF
// butterfly sequencer so the sequencer, the data buffer and the twiddle ROM
// bridge share one connection.
//
// Signals:
//   start      - one-cycle request to begin a transform (into the sequencer)
//   busy       - a transform is being sequenced
//   done       - one-cycle completion pulse
//   bfly_valid - a butterfly is issued this cycle
//   addr_a     - upper-leg data address
//   addr_b     - lower-leg data address (addr_a + half)
//   stage      - current stage index
//   tact_rom   - twiddle request, identical to bfly_valid
//   ta_rom     - twiddle index
//   evenOdd    - 0 = fetch a new twiddle, 1 = reuse the previous one
//
// Modports:
//   master - the sequencer (drives everything except start)
//   slave  - the consumer side (drives start, observes the rest)
// -----------------------------------------------------------------------------
interface fft_butterfly_sequencer_if #(
  parameter int FFT_N = 10
);

  localparam int STAGE_W = (FFT_N > 1) ? $clog2(FFT_N) : 1;

  logic               start;
  logic               busy;
  logic               done;
  logic               bfly_valid;
  logic [FFT_N-1:0]   addr_a;
  logic [FFT_N-1:0]   addr_b;
  logic [STAGE_W-1:0] stage;
  logic               tact_rom;
  logic [FFT_N-2:0]   ta_rom;
  logic               evenOdd;

  modport master (
    input  start,
    output busy,
    output done,
    output bfly_valid,
    output addr_a,
    output addr_b,
    output stage,
    output tact_rom,
    output ta_rom,
    output evenOdd
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    input  bfly_valid,
    input  addr_a,
    input  addr_b,
    input  stage,
    input  tact_rom,
    input  ta_rom,
    input  evenOdd
  );

endinterface

// File: rtl/fft_butterfly_sequencer.sv
// -----------------------------------------------------------------------------
// fft_butterfly_sequencer
//
// Purpose: radix-2 decimation-in-frequency butterfly scheduler. On start it
// walks every stage s = 0..FFT_N-1 of a 2^FFT_N point transform. Within a
// stage the butterfly index k (0..half-1) is the outer loop and the group
// index g (0..groups-1) the inner loop, with half = 2^(FFT_N-1-s) and
// groups = 2^s. Each issue drives:
//   addr_a = g*2*half + k, addr_b = addr_a + half, ta_rom = k << s.
// Because the inner loop runs over groups, consecutive butterflies share a
// twiddle whenever groups > 1, which lets the twiddle bridge skip a ROM fetch
// (evenOdd = 1). A fetch is never issued in the cycle right after another
// fetch; the sequencer inserts a one-cycle bubble instead, so the single-port
// quarter-wave cosine ROM never sees back-to-back reads.
//
// Parameters:
//   FFT_N     - log2 of the transform length (>= 2)
//   STAGE_GAP - idle cycles between stages (1..15), covers pipeline drain
//
// Ports:
//   clk - clock
//   rst - synchronous, active-high reset
//   bus - fft_butterfly_sequencer_if.master (start in; busy, done,
//         bfly_valid, addr_a, addr_b, stage, tact_rom, ta_rom, evenOdd out)
//
// Configuration macro:
//   FFT_SEQ_TWIDDLE_REUSE_EN - when defined, butterflies whose twiddle equals
//   the previous one in the stage are issued with evenOdd = 1 and never stall.
//   When undefined every butterfly is a fetch (evenOdd = 0), so each stage
//   issues one butterfly every other cycle. Ordering and addresses are the
//   same either way.
//
// All outputs are registered. Outside an issue cycle addr_a, addr_b, ta_rom
// and evenOdd hold their last issued values.
// -----------------------------------------------------------------------------
module fft_butterfly_sequencer #(
  parameter int FFT_N     = 10,
  parameter int STAGE_GAP = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  fft_butterfly_sequencer_if.master  bus
);

  localparam int STAGE_W = (FFT_N > 1) ? $clog2(FFT_N) : 1;
  localparam int TW_W    = FFT_N - 1;

  localparam logic [FFT_N-1:0]   ZERO_N     = FFT_N'(0);
  localparam logic [FFT_N-1:0]   ONE_N      = FFT_N'(1);
  localparam logic [FFT_N-1:0]   HALF_INIT  = ONE_N << (FFT_N - 1);
  localparam logic [TW_W-1:0]    TW_ZERO    = TW_W'(0);
  localparam logic [TW_W-1:0]    TW_ONE     = TW_W'(1);
  localparam logic [STAGE_W-1:0] STAGE_ZERO = STAGE_W'(0);
  localparam logic [STAGE_W-1:0] STAGE_ONE  = STAGE_W'(1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(FFT_N - 1);
  localparam logic [3:0]         GAP_LOAD   = 4'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t r_state;

  // Position of the next butterfly to issue and geometry of the current stage.
  logic [STAGE_W-1:0] r_stage;
  logic [FFT_N-1:0]   r_half;       // 2^(FFT_N-1-s): leg distance and k count
  logic [FFT_N-1:0]   r_grp_last;   // groups-1, an all-ones mask of s bits
  logic [FFT_N-1:0]   r_k;          // outer loop: butterfly within group
  logic [FFT_N-1:0]   r_g;          // inner loop: group index
  logic [FFT_N-1:0]   r_off;        // g*2*half, kept incrementally
  logic [TW_W-1:0]    r_tw;         // k << s, kept incrementally (k*groups)
  logic               r_prev_fetch; // a fetch was issued in the current cycle
  logic [3:0]         r_gap_cnt;

  // Registered outputs.
  logic               r_busy;
  logic               r_done;
  logic               r_valid;
  logic [FFT_N-1:0]   r_addr_a;
  logic [FFT_N-1:0]   r_addr_b;
  logic [TW_W-1:0]    r_ta_rom;
  logic               r_even_odd;

  // Combinational view of the pending butterfly.
  logic               w_g_last;
  logic               w_k_last;
  logic               w_stage_end;
  logic [FFT_N-1:0]   w_addr_a;
  logic [FFT_N-1:0]   w_addr_b;
  logic [TW_W-1:0]    w_tw_step;
  logic               w_reuse;
  logic               w_stall;
  logic               w_issue_req;

  // Decode the pending butterfly: addresses, loop ends, reuse and ROM stall.
  always_comb begin
    w_g_last    = (r_g == r_grp_last);
    w_k_last    = (r_k == (r_half - ONE_N));
    w_stage_end = w_g_last && w_k_last;
    w_addr_a    = r_off + r_k;
    w_addr_b    = w_addr_a + r_half;
    // groups = grp_last + 1; in the last stage this wraps to 0, but there
    // half = 1 so k never advances within that stage.
    w_tw_step   = r_grp_last[TW_W-1:0] + TW_ONE;
`ifdef FFT_SEQ_TWIDDLE_REUSE_EN
    // k = g = 0 is the first butterfly of a stage and always fetches.
    w_reuse     = ((r_k != ZERO_N) || (r_g != ZERO_N)) && (r_tw == r_ta_rom);
`else
    w_reuse     = 1'b0;
`endif
    // Only a fetch following a fetch issue has to wait one cycle.
    w_stall     = !w_reuse && r_prev_fetch;
    // From IDLE the first butterfly is issued on the same edge that sees
    // start, so busy and the first issue appear together.
    w_issue_req = (r_state == ST_ISSUE) || ((r_state == ST_IDLE) && bus.start);
  end

  // Sequencer FSM, loop counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_stage      <= STAGE_ZERO;
      r_half       <= HALF_INIT;
      r_grp_last   <= ZERO_N;
      r_k          <= ZERO_N;
      r_g          <= ZERO_N;
      r_off        <= ZERO_N;
      r_tw         <= TW_ZERO;
      r_prev_fetch <= 1'b0;
      r_gap_cnt    <= 4'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_valid      <= 1'b0;
      r_addr_a     <= ZERO_N;
      r_addr_b     <= ZERO_N;
      r_ta_rom     <= TW_ZERO;
      r_even_odd   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_ISSUE: begin
          if (w_issue_req) begin
            if (w_stall) begin
              // Bubble: counters and data outputs hold, only valid drops.
              r_valid      <= 1'b0;
              r_prev_fetch <= 1'b0;
            end else begin
              r_busy       <= 1'b1;
              r_valid      <= 1'b1;
              r_addr_a     <= w_addr_a;
              r_addr_b     <= w_addr_b;
              r_ta_rom     <= r_tw;
              r_even_odd   <= w_reuse;
              r_prev_fetch <= !w_reuse;
              if (w_g_last) begin
                r_g   <= ZERO_N;
                r_off <= ZERO_N;
                r_k   <= r_k + ONE_N;
                r_tw  <= r_tw + w_tw_step;
              end else begin
                r_g   <= r_g + ONE_N;
                r_off <= r_off + {r_half[FFT_N-2:0], 1'b0};
              end
              if (w_stage_end) begin
                if (r_stage == STAGE_LAST) begin
                  r_state <= ST_FINISH;
                end else begin
                  r_state   <= ST_GAP;
                  r_gap_cnt <= GAP_LOAD;
                end
              end else begin
                r_state <= ST_ISSUE;
              end
            end
          end else begin
            r_valid      <= 1'b0;
            r_prev_fetch <= 1'b0;
          end
        end

        ST_GAP: begin
          r_valid      <= 1'b0;
          r_prev_fetch <= 1'b0;
          if (r_gap_cnt == 4'd0) begin
            // Step to the next stage: half halves, groups doubles.
            r_state    <= ST_ISSUE;
            r_stage    <= r_stage + STAGE_ONE;
            r_half     <= {1'b0, r_half[FFT_N-1:1]};
            r_grp_last <= {r_grp_last[FFT_N-2:0], 1'b1};
            r_k        <= ZERO_N;
            r_g        <= ZERO_N;
            r_off      <= ZERO_N;
            r_tw       <= TW_ZERO;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end

        ST_FINISH: begin
          // Completion: done pulses while busy falls; geometry rearms for
          // the next start so IDLE can issue straight from the registers.
          r_state      <= ST_IDLE;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_valid      <= 1'b0;
          r_prev_fetch <= 1'b0;
          r_stage      <= STAGE_ZERO;
          r_half       <= HALF_INIT;
          r_grp_last   <= ZERO_N;
          r_k          <= ZERO_N;
          r_g          <= ZERO_N;
          r_off        <= ZERO_N;
          r_tw         <= TW_ZERO;
        end

        default: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_valid      <= 1'b0;
          r_prev_fetch <= 1'b0;
          r_stage      <= STAGE_ZERO;
          r_half       <= HALF_INIT;
          r_grp_last   <= ZERO_N;
          r_k          <= ZERO_N;
          r_g          <= ZERO_N;
          r_off        <= ZERO_N;
          r_tw         <= TW_ZERO;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.bfly_valid = r_valid;
  assign bus.tact_rom   = r_valid;
  assign bus.addr_a     = r_addr_a;
  assign bus.addr_b     = r_addr_b;
  assign bus.stage      = r_stage;
  assign bus.ta_rom     = r_ta_rom;
  assign bus.evenOdd    = r_even_odd;

endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft_butterfly_sequencer
//
// Self-checking bench for fft_butterfly_sequencer (FFT_N = 4, STAGE_GAP = 4).
// A behavioural model builds the full list of expected issues (cycle,
// addresses, twiddle, reuse flag, stage) from the loop definitions each time
// it sees an honoured start; one compare process checks every output every
// cycle against it. Literal expectations for the directed runs pin the model.
// -----------------------------------------------------------------------------
module tb_fft_butterfly_sequencer;

  localparam int N_LOG = 4;
  localparam int GAP   = 4;
  localparam int NBF   = 1 << (N_LOG - 1);
`ifdef FFT_SEQ_TWIDDLE_REUSE_EN
  localparam bit REUSE    = 1'b1;
  localparam int LAST_REL = 51;
`else
  localparam bit REUSE    = 1'b0;
  localparam int LAST_REL = 72;
`endif

  logic clk = 1'b0;
  logic rst;

  fft_butterfly_sequencer_if #(.FFT_N(N_LOG)) bus ();

  fft_butterfly_sequencer #(.FFT_N(N_LOG), .STAGE_GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int a;
    int b;
    int ta;
    int eo;
    int st;
  } bfly_t;

  bfly_t exp_q[$];
  bfly_t obs_q[$];
  int    obs_done[$];

  int   cyc = 0;
  logic s_rst;
  logic s_start;
  int   n_checks = 0;
  int   n_fail   = 0;

  bit m_init     = 1'b0;
  int m_first    = -10;
  int m_done_cyc = -10;
  int held_a  = 0;
  int held_b  = 0;
  int held_ta = 0;
  int held_eo = 0;
  bit prev_fetch_obs = 1'b0;

  // Cycle counter and the inputs as the DUT sampled them at this edge.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    s_rst   <= rst;
    s_start <= bus.start;
  end

  function automatic void check(input string name, input logic [31:0] act, input int expv);
    n_checks++;
    if (act !== 32'(expv)) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endfunction

  // Expected issue list for a transform whose first issue is in cycle 'first'.
  task automatic build_schedule(input int first);
    int t, last_t, prev_fetch_t, prev_ta, half, groups, a, ta, eo;
    bfly_t e;
    exp_q.delete();
    t = first;
    last_t = first;
    prev_fetch_t = -100;
    prev_ta = -1;
    for (int s = 0; s < N_LOG; s++) begin
      half   = 1 << (N_LOG - 1 - s);
      groups = 1 << s;
      if (s > 0) t = last_t + GAP + 1;
      for (int k = 0; k < half; k++) begin
        for (int g = 0; g < groups; g++) begin
          a  = g * 2 * half + k;
          ta = (k << s) & (NBF - 1);
          eo = (REUSE && !(k == 0 && g == 0) && ta == prev_ta) ? 1 : 0;
          if (eo == 0 && prev_fetch_t == t - 1) t = t + 1;
          e.cyc = t; e.a = a; e.b = a + half; e.ta = ta; e.eo = eo; e.st = s;
          exp_q.push_back(e);
          if (eo == 0) prev_fetch_t = t;
          prev_ta = ta;
          last_t = t;
          t = t + 1;
        end
      end
    end
    m_first    = first;
    m_done_cyc = last_t + 1;
  endtask

  // Compare process: advance the model by one edge, then check all outputs.
  initial begin
    bfly_t e;
    bfly_t o;
    bit    ev;
    bit    cur_fetch;
    forever begin
      @(negedge clk);
      if (s_rst === 1'b1) begin
        m_init = 1'b1;
        exp_q.delete();
        m_first = -10; m_done_cyc = -10;
        held_a = 0; held_b = 0; held_ta = 0; held_eo = 0;
      end else if (m_init && s_start === 1'b1 && cyc > m_done_cyc) begin
        build_schedule(cyc);
      end
      if (m_init) begin
        ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check("bfly_valid", bus.bfly_valid, ev);
        check("tact_rom", bus.tact_rom, ev);
        check("busy", bus.busy, (cyc >= m_first && cyc < m_done_cyc));
        check("done", bus.done, (cyc == m_done_cyc));
        if (ev) begin
          e = exp_q.pop_front();
          held_a = e.a; held_b = e.b; held_ta = e.ta; held_eo = e.eo;
          check("stage", bus.stage, e.st);
        end else if (s_rst === 1'b1) begin
          check("stage_rst", bus.stage, 0);
        end
        check("addr_a", bus.addr_a, held_a);
        check("addr_b", bus.addr_b, held_b);
        check("ta_rom", bus.ta_rom, held_ta);
        check("evenOdd", bus.evenOdd, held_eo);
        cur_fetch = (bus.tact_rom === 1'b1) && (bus.evenOdd === 1'b0);
        check("rom_back_to_back", (prev_fetch_obs && cur_fetch), 0);
        prev_fetch_obs = cur_fetch;
        if (bus.bfly_valid === 1'b1) begin
          o.cyc = cyc; o.a = int'(bus.addr_a); o.b = int'(bus.addr_b);
          o.ta = int'(bus.ta_rom); o.eo = int'(bus.evenOdd); o.st = int'(bus.stage);
          obs_q.push_back(o);
        end
        if (bus.done === 1'b1) obs_done.push_back(cyc);
      end
    end
  end

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_start(input int c);
    go_to(c);
    bus.start = 1'b1;
    go_to(c + 1);
    bus.start = 1'b0;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_done.delete();
  endtask

  // Hand-computed expectations for one full transform started in cycle b.
  task automatic pin_full(input int b);
    check("model_done_cycle", m_done_cyc - b, LAST_REL + 1);
    check("issue_count", obs_q.size(), 32);
    if (obs_q.size() == 32) begin
      check("first_issue_cycle", obs_q[0].cyc - b, 1);
      check("last_issue_cycle", obs_q[31].cyc - b, LAST_REL);
      for (int k = 0; k < 8; k++) begin
        check("s0_addr_a", obs_q[k].a, k);
        check("s0_addr_b", obs_q[k].b, k + 8);
        check("s0_ta", obs_q[k].ta, k);
        check("s0_evenOdd", obs_q[k].eo, 0);
        if (k > 0) check("s0_spacing", obs_q[k].cyc - obs_q[k-1].cyc, 2);
      end
      for (int i = 0; i < 8; i++) begin
        check("s1_ta", obs_q[8 + i].ta, (i / 2) * 2);
        check("s1_evenOdd", obs_q[8 + i].eo, REUSE ? (i % 2) : 0);
        check("s3_addr_a", obs_q[24 + i].a, 2 * i);
        check("s3_ta", obs_q[24 + i].ta, 0);
        check("s3_evenOdd", obs_q[24 + i].eo, (REUSE && i != 0) ? 1 : 0);
      end
    end
    check("done_count", obs_done.size(), 1);
    if (obs_done.size() == 1) check("done_cycle", obs_done[0] - b, LAST_REL + 1);
  endtask

  initial begin
    int b;
    int d;
    rst = 1'b1;
    bus.start = 1'b0;

    // Reset held 3 cycles with a start pulse inside it.
    go_to(1);
    bus.start = 1'b1;
    go_to(2);
    bus.start = 1'b0;
    go_to(3);
    rst = 1'b0;
    go_to(6);
    check("no_issue_after_reset", obs_q.size(), 0);

    // Plain full transform.
    b = cyc;
    clear_obs();
    drive_start(b);
    go_to(b + 85);
    pin_full(b);

    // Start pulses while busy are ignored.
    b = cyc;
    clear_obs();
    drive_start(b);
    drive_start(b + 10);
    drive_start(b + 30);
    go_to(b + 85);
    pin_full(b);

    // Reset mid-transform (with a coincident start), then a fresh start.
    b = cyc;
    drive_start(b);
    go_to(b + 20);
    rst = 1'b1;
    bus.start = 1'b1;
    go_to(b + 21);
    rst = 1'b0;
    bus.start = 1'b0;
    go_to(b + 22);
    clear_obs();
    drive_start(b + 25);
    go_to(b + 25 + 85);
    pin_full(b + 25);

    // Randomised start pulses and occasional resets; the model tracks all.
    for (int it = 0; it < 6; it++) begin
      d = int'($urandom_range(0, 6));
      b = cyc + d;
      drive_start(b);
      for (int i = 2; i < LAST_REL + 8; i++) begin
        go_to(b + i);
        bus.start = ($urandom_range(0, 7) == 0);
        rst = ($urandom_range(0, 119) == 0);
      end
      go_to(cyc + 1);
      bus.start = 1'b0;
      rst = 1'b0;
      go_to(cyc + 85);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_butterfly_sequencer.md
# fft_butterfly_sequencer

Radix-2 decimation-in-frequency butterfly scheduler for the R2FFT core. On `start` it walks every stage and butterfly of an N-point transform. For each butterfly it issues the data-buffer pair addresses and the twiddle request (`tact_rom`, `ta_rom`, `evenOdd`) that feed `twiddleFactorRomBridge` directly. It orders butterflies so that consecutive butterflies reuse a twiddle where possible, and it inserts bubbles so the single-port quarter-wave cosine ROM is never asked for two fetches in back-to-back cycles.

## Interface
Parameters:
- `FFT_N`, 10, log2 of transform length.
- `STAGE_GAP`, 4, idle cycles between the last issue of one stage and the first issue of the next. Legal range is 1..15. This covers butterfly pipeline drain.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to begin a transform. Honoured only while idle.
- `busy`  out  1  high while a transform is being sequenced.
- `done`  out  1  one-cycle pulse at completion.
- `bfly_valid`  out  1  a butterfly is issued this cycle.
- `addr_a`  out  FFT_N  upper-leg data address.
- `addr_b`  out  FFT_N  lower-leg data address, equal to `addr_a` + half.
- `stage`  out  $clog2(FFT_N)  current stage index.
- `tact_rom`  out  1  twiddle request. Identical to `bfly_valid`.
- `ta_rom`  out  FFT_N-1  twiddle index.
- `evenOdd`  out  1  0 = fetch a new twiddle, 1 = reuse the previously fetched twiddle.

## Operation
State machine states:
- IDLE → ISSUE on `start`.
- ISSUE → GAP after the last butterfly of a stage, when stages remain.
- GAP → ISSUE after `STAGE_GAP` cycles, with `stage` incremented.
- ISSUE → FINISH after the last butterfly of stage FFT_N-1.
- FINISH → IDLE after one cycle, with `done` high in FINISH.

Stage geometry, for stage s = 0..FFT_N-1:
- half = 2^(FFT_N-1-s); groups = 2^s.
- Loop k = 0..half-1 is outer; loop g = 0..groups-1 is inner.
- `addr_a` = g·2·half + k.
- `addr_b` = `addr_a` + half.
- `ta_rom` = k << s, truncated to FFT_N-1 bits.
- Each stage has 2^(FFT_N-1) butterflies.

Twiddle reuse rules:
- `evenOdd` = 1 when `ta_rom` equals the `ta_rom` of the previous issued butterfly in the same stage.
- The first butterfly of every stage has `evenOdd` = 0.

ROM conflict rule:
- A fetch butterfly (`evenOdd` = 0) is not issued in the cycle immediately after another fetch issue.
- In that cycle the sequencer holds its counters and drives `bfly_valid` = 0, which is one bubble.
- Reuse butterflies never stall.
- Effect per stage: stage 0 (every twiddle distinct) issues every other cycle. Stages ≥1 issue every cycle.

Output defaults and limits:
- When `bfly_valid` = 0, `addr_a`, `addr_b`, `ta_rom` and `evenOdd` hold their last values. `evenOdd` must not toggle during a bubble.
- `start` while busy is ignored.
- A `start` pulse coincident with `rst` is ignored.
- No backpressure input: the downstream datapath is fully pipelined.

## Timing
- All outputs are registered.
- Reset values: `busy` = 0, `done` = 0, `bfly_valid` = 0, `tact_rom` = 0, `evenOdd` = 0, `addr_a` = 0, `addr_b` = 0, `ta_rom` = 0, `stage` = 0. State returns to IDLE.
- `start` sampled high in cycle t: `busy` = 1 and the first issue occur in cycle t+1.
- `done` pulses one cycle after the final issue. `busy` falls in the same cycle `done` rises.
- The twiddle for an issue in cycle t appears at the bridge outputs in cycle t+3. Downstream delays the butterfly data 3 cycles to match.
- `rst` mid-transform: next cycle is IDLE with all reset values. No `done` pulse is produced.

## Configuration
- `FFT_SEQ_TWIDDLE_REUSE_EN` defined: reuse ordering and `evenOdd` = 1 as specified above.
- Not defined: every butterfly drives `evenOdd` = 0, so every stage issues one butterfly per 2 cycles (2^FFT_N − 1 cycles per stage). Addresses and ordering are unchanged.

## Test plan
- **Reset values:** hold `rst` 3 cycles while pulsing `start` → all outputs at reset values, no issue.
- **Full transform, reuse on:** FFT_N=4, STAGE_GAP=4, `start` at cycle 0 → 32 issues; first issue cycle 1, last issue cycle 51, `done` at cycle 52.
  - Stage 0: `ta_rom` 0..7, `addr_a` = k, `addr_b` = k+8, `evenOdd` always 0, a bubble between each issue.
  - Stage 1: `ta_rom` 0,0,2,2,4,4,6,6; `evenOdd` 0,1,0,1…
  - Stage 3: `ta_rom` all 0; `evenOdd` 0 then seven 1s; `addr_a` 0,2,4…14.
- **Reuse compiled out:** same stimulus without the macro → every `evenOdd` = 0; last issue cycle 72, `done` at cycle 73.
- **Conflict checker:** assertion over every run → never `tact_rom && !evenOdd` in two consecutive cycles; no `evenOdd` change while `bfly_valid` = 0.
- **Start while busy:** `start` pulsed at cycles 10 and 30 → ignored; same 32 issues and `done` timing as the full-transform case.
- **Reset mid-transform:** `rst` at cycle 20 for 1 cycle → cycle 21 idle with reset values, no `done`. A new `start` at cycle 25 produces a full transform, first issue at cycle 26.
